ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
//
// PURPOSE
//  Parametrised key-state tracker. It sits between the PS/2 byte receiver and the game FSMs.
//  It decodes a stream of scan-code bytes, including F0 break and E0 extended prefixes, into
//  per-key held levels and single-cycle press/release pulses for NUM_KEYS configurable keys.
//  Typematic repeats are suppressed. Stalled prefix sequences are timed out.
//
// PARAMETERS
//  NUM_KEYS        4                              number of tracked keys (>=1)
//  KEY_CODES       {8'h1E,8'h16,8'h5A,8'h29}      packed codes; key i = KEY_CODES[8*i +: 8]
//                                                 (defaults: 0=space, 1=enter, 2='1', 3='2')
//  KEY_EXT         4'b0000                        bit i=1: key i is an E0-extended key
//  TIMEOUT_CYCLES  2_500_000                      idle cycles in a prefix state before abort;
//                                                 0 disables the timeout
//  localparam IDX_W = (NUM_KEYS>1) ? $clog2(NUM_KEYS) : 1
//
// PORTS
//  CLOCK_50      in   1         system clock, rising edge
//  resetn        in   1         asynchronous, active-low reset
//  ps2_byte      in   8         received scan-code byte
//  ps2_byte_en   in   1         1-cycle strobe: ps2_byte is valid
//  key_held      out  NUM_KEYS  level: key i currently held
//  key_press     out  NUM_KEYS  1-cycle pulse on a 0->1 change of key_held[i]
//  key_release   out  NUM_KEYS  1-cycle pulse on a 1->0 change of key_held[i]
//  any_held      out  1         OR of key_held (registered, same cycle as key_held)
//  last_key      out  IDX_W     index of the most recently pressed key
//  protocol_err  out  1         1-cycle pulse when a prefix sequence times out
//
// BEHAVIOUR
//  - Reset (resetn=0, async): all outputs 0, FSM in IDLE, timeout counter 0.
//  - Bytes are sampled only when ps2_byte_en=1. All outputs are registered.
//  - Latency: the final byte of a sequence at edge N updates outputs at edge N (visible in
//    cycle N+1). Pulses last exactly one cycle.
//  - FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
//    - 8'hE0: any state -> GOT_E0.
//    - 8'hF0: IDLE -> GOT_F0; GOT_E0 -> GOT_E0F0; GOT_F0 and GOT_E0F0 hold their state.
//    - Other byte in IDLE: make, ext=0. In GOT_E0: make, ext=1. In GOT_F0: break, ext=0.
//      In GOT_E0F0: break, ext=1. Each of these then returns to IDLE.
//  - Match rule: key i matches when code == KEY_CODES[i] and ext == KEY_EXT[i]. Every matching
//    index is updated, so duplicate codes are allowed. An unmatched code is consumed silently.
//  - Make on a key already held: no pulse, no change (typematic repeat suppression).
//    Break on a key not held: no pulse.
//  - last_key loads the lowest matching index on each accepted make that raises key_held.
//  - Timeout: in any non-IDLE state the counter increments each cycle without a strobe and
//    clears on every strobe. When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE, protocol_err pulses,
//    key_held is unchanged. In IDLE the counter is held at 0.
//  - Reset mid-sequence: the partial prefix is discarded and all keys are released without
//    release pulses.
//
// CONFIGURATION
//  KEY_TRACKER_EXT_EN defined: E0 handling as above; KEY_EXT is honoured.
//  Not defined: GOT_E0 and GOT_E0F0 are not built. 8'hE0 is consumed with no state change.
//  KEY_EXT is ignored (ext treated as 0), so extended keys alias their base codes.
//
// TESTING
//  1. Reset asserted mid-stream -> all outputs 0. After release, strobe 8'h29 -> key_held=4'b0001,
//     key_press=4'b0001 for 1 cycle, last_key=0.
//  2. 8'h29 strobed 5x, then 8'hF0, 8'h29 -> one press pulse only; key_release[0] for 1 cycle;
//     any_held returns to 0.
//  3. Hold 8'h5A, then press 8'h1E -> key_held=4'b1010, last_key=3. Break 8'h5A ->
//     key_held=4'b1000, key_release=4'b0010.
//  4. With macro, KEY_EXT[1]=1: 8'h5A -> no change. 8'hE0,8'h5A -> key_held[1]=1.
//     8'hE0,8'hF0,8'h5A -> release. Without macro: 8'hE0,8'h5A -> key_held[1]=1.
//  5. TIMEOUT_CYCLES=16: strobe 8'hF0, wait 16 cycles -> protocol_err 1-cycle pulse.
//     Then 8'h16 -> treated as make, key_held[2]=1.
//  6. Unmapped 8'h1C make/break, and 8'hF0,8'hF0,8'h16 -> no outputs for 1C; key 2 released once.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 scan-code bytes (F0 break, E0 extended) into per-key held
// levels plus one-cycle press/release pulses; typematic repeats suppressed, stalled prefixes
// time out. Latency: final byte at edge N -> outputs visible in cycle N+1. No backpressure.
// Optional feature macro: KEY_TRACKER_EXT_EN (builds E0-extended handling, honours KEY_EXT).
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   ps2_byte     in   [7:0] received scan-code byte
//   ps2_byte_en  in   one-cycle strobe qualifying ps2_byte
//   key_held     out  [NUM_KEYS-1:0] level per tracked key
//   key_press    out  [NUM_KEYS-1:0] one-cycle pulse on held 0->1
//   key_release  out  [NUM_KEYS-1:0] one-cycle pulse on held 1->0
//   any_held     out  OR of key_held, registered alongside it
//   last_key     out  [IDX_W-1:0] index of most recently pressed key
//   protocol_err out  one-cycle pulse when a prefix sequence times out
module ps2_key_tracker #(
  parameter int                      NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = {8'h1E, 8'h16, 8'h5A, 8'h29},
  parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
  parameter int                      TIMEOUT_CYCLES = 2_500_000,
  localparam int                     IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          ps2_byte,
  input  logic                ps2_byte_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_held,
  output logic [IDX_W-1:0]    last_key,
  output logic                protocol_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef KEY_TRACKER_EXT_EN
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  // Which KEY_EXT bits take part in matching.
  localparam logic [NUM_KEYS-1:0] EXT_MASK = '1;
`else
  typedef enum logic [0:0] {IDLE, GOT_F0} state_t;
  // Extended handling absent: every key matches as a base (ext=0) code.
  localparam logic [NUM_KEYS-1:0] EXT_MASK = '0;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_KEYS-1:0]  r_held;
  logic [NUM_KEYS-1:0]  r_press;
  logic [NUM_KEYS-1:0]  r_release;
  logic                 r_any;
  logic [IDX_W-1:0]     r_last;
  logic                 r_perr;

  logic                 w_is_e0;
  logic                 w_is_f0;
  logic                 w_code_vld;
  logic                 w_brk;
  logic                 w_ext;
  logic                 w_timeout;
  logic [NUM_KEYS-1:0]  w_match;
  logic [NUM_KEYS-1:0]  w_held_nxt;
  logic [IDX_W-1:0]     w_low_idx;

  assign w_is_e0 = (ps2_byte == 8'hE0);
  assign w_is_f0 = (ps2_byte == 8'hF0);

  // A strobe in the same cycle always wins over the timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state != IDLE) && !ps2_byte_en &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and byte classification.
  always_comb begin
    w_state_nxt = r_state;
    w_code_vld  = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (ps2_byte_en) begin
      if (w_is_e0) begin
`ifdef KEY_TRACKER_EXT_EN
        w_state_nxt = GOT_E0;
`else
        w_state_nxt = r_state;
`endif
      end else if (w_is_f0) begin
        case (r_state)
          IDLE:    w_state_nxt = GOT_F0;
`ifdef KEY_TRACKER_EXT_EN
          GOT_E0:  w_state_nxt = GOT_E0F0;
`endif
          default: w_state_nxt = r_state;
        endcase
      end else begin
        w_code_vld  = 1'b1;
        w_state_nxt = IDLE;
`ifdef KEY_TRACKER_EXT_EN
        w_brk = (r_state == GOT_F0) || (r_state == GOT_E0F0);
        w_ext = (r_state == GOT_E0) || (r_state == GOT_E0F0);
`else
        w_brk = (r_state == GOT_F0);
`endif
      end
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
    end
  end

  // Key matching, next held vector and lowest-index priority encode.
  always_comb begin
    w_match   = '0;
    w_low_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_match[i] = (ps2_byte == KEY_CODES[8*i +: 8]) && (w_ext == (KEY_EXT[i] & EXT_MASK[i]));
    end
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_low_idx = IDX_W'(i);
    end
    w_held_nxt = r_held;
    if (w_code_vld) begin
      w_held_nxt = w_brk ? (r_held & ~w_match) : (r_held | w_match);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_held    <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_any     <= 1'b0;
      r_last    <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_held    <= w_held_nxt;
      r_press   <= w_held_nxt & ~r_held;
      r_release <= r_held & ~w_held_nxt;
      r_any     <= |w_held_nxt;
      r_perr    <= w_timeout;
      // Only a make that actually raises a held bit moves last_key.
      if (|(w_held_nxt & ~r_held)) r_last <= w_low_idx;
      if ((r_state == IDLE) || ps2_byte_en || w_timeout) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign key_held     = r_held;
  assign key_press    = r_press;
  assign key_release  = r_release;
  assign any_held     = r_any;
  assign last_key     = r_last;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: two instances share the byte stream, u_a with no
// extended keys, u_b with key 1 (8'h5A) marked extended. Outputs sampled on falling edges.
module tb_ps2_key_tracker;

  logic       clk;
  logic       rst_n;
  logic [7:0] byte_dat;
  logic       byte_vld;

  logic [3:0] a_held, a_press, a_rel;
  logic       a_any, a_perr;
  logic [1:0] a_last;
  logic [3:0] b_held, b_press, b_rel;
  logic       b_any, b_perr;
  logic [1:0] b_last;

  int n_tests;
  int n_fail;

  ps2_key_tracker #(.NUM_KEYS(4), .KEY_CODES({8'h1E, 8'h16, 8'h5A, 8'h29}),
                    .KEY_EXT(4'b0000), .TIMEOUT_CYCLES(16)) u_a (
    .CLOCK_50(clk), .resetn(rst_n), .ps2_byte(byte_dat), .ps2_byte_en(byte_vld),
    .key_held(a_held), .key_press(a_press), .key_release(a_rel), .any_held(a_any),
    .last_key(a_last), .protocol_err(a_perr));

  ps2_key_tracker #(.NUM_KEYS(4), .KEY_CODES({8'h1E, 8'h16, 8'h5A, 8'h29}),
                    .KEY_EXT(4'b0010), .TIMEOUT_CYCLES(16)) u_b (
    .CLOCK_50(clk), .resetn(rst_n), .ps2_byte(byte_dat), .ps2_byte_en(byte_vld),
    .key_held(b_held), .key_press(b_press), .key_release(b_rel), .any_held(b_any),
    .last_key(b_last), .protocol_err(b_perr));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the byte is taken on the next rising edge and the
  // task returns at the following falling edge, where the result is visible.
  task automatic send(input logic [7:0] b);
    byte_dat = b;
    byte_vld = 1'b1;
    @(negedge clk);
    byte_vld = 1'b0;
    byte_dat = 8'h00;
  endtask

  int k;
  int perr_seen;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    byte_vld = 1'b0;
    byte_dat = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_held", a_held, 4'b0000);
    check("rst_press", a_press, 4'b0000);
    check("rst_release", a_rel, 4'b0000);
    check("rst_any", a_any, 1'b0);
    check("rst_last", a_last, 2'd0);
    check("rst_perr", a_perr, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset mid-stream, then first make
    send(8'h5A);
    check("t1_pre_held", a_held, 4'b0010);
    send(8'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_held", a_held, 4'b0000);
    check("t1_async_any", a_any, 1'b0);
    check("t1_async_rel", a_rel, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h29);
    check("t1_held", a_held, 4'b0001);
    check("t1_press", a_press, 4'b0001);
    check("t1_any", a_any, 1'b1);
    check("t1_last", a_last, 2'd0);
    @(negedge clk);
    check("t1_press_width", a_press, 4'b0000);

    // 2: typematic repeats, then break
    for (int i = 0; i < 4; i++) begin
      send(8'h29);
      check("t2_repeat_press", a_press, 4'b0000);
      check("t2_repeat_held", a_held, 4'b0001);
    end
    send(8'hF0);
    check("t2_f0_held", a_held, 4'b0001);
    send(8'h29);
    check("t2_held", a_held, 4'b0000);
    check("t2_release", a_rel, 4'b0001);
    check("t2_any", a_any, 1'b0);
    @(negedge clk);
    check("t2_release_width", a_rel, 4'b0000);

    // 3: two keys, last_key, partial break
    send(8'h5A);
    check("t3_held_a", a_held, 4'b0010);
    check("t3_last_a", a_last, 2'd1);
    send(8'h1E);
    check("t3_held_b", a_held, 4'b1010);
    check("t3_press_b", a_press, 4'b1000);
    check("t3_last_b", a_last, 2'd3);
    send(8'hF0);
    send(8'h5A);
    check("t3_held_c", a_held, 4'b1000);
    check("t3_release_c", a_rel, 4'b0010);
    check("t3_last_c", a_last, 2'd3);
    check("t3_any_c", a_any, 1'b1);
    send(8'hF0);
    send(8'h1E);
    check("t3_held_d", a_held, 4'b0000);

    // 4: extended keys
`ifdef KEY_TRACKER_EXT_EN
    send(8'h5A);
    check("t4_base_on_ext", b_held, 4'b0000);
    send(8'hF0);
    send(8'h5A);
    send(8'hE0);
    send(8'h5A);
    check("t4_ext_held", b_held, 4'b0010);
    check("t4_ext_press", b_press, 4'b0010);
    check("t4_ext_not_base", a_held, 4'b0000);
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    check("t4_ext_release", b_rel, 4'b0010);
    check("t4_ext_held_off", b_held, 4'b0000);
`else
    send(8'hE0);
    send(8'h5A);
    check("t4_alias_held", b_held, 4'b0010);
    check("t4_alias_press", b_press, 4'b0010);
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    check("t4_alias_release", b_rel, 4'b0010);
    check("t4_alias_held_off", b_held, 4'b0000);
`endif

    // 5: timeout of a stalled F0
    send(8'h29);
    check("t5_pre_held", a_held, 4'b0001);
    send(8'hF0);
    k = 0;
    while (a_perr !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_timeout_cycles", k, 16);
    check("t5_held_kept", a_held, 4'b0001);
    check("t5_no_release", a_rel, 4'b0000);
    @(negedge clk);
    check("t5_perr_width", a_perr, 1'b0);
    send(8'h16);
    check("t5_make_after", a_held, 4'b0101);
    check("t5_press_after", a_press, 4'b0100);
    check("t5_last_after", a_last, 2'd2);

    // 6: unmapped code and doubled F0
    send(8'h1C);
    check("t6_unmapped_make", a_press, 4'b0000);
    send(8'hF0);
    send(8'h1C);
    check("t6_unmapped_break", a_rel, 4'b0000);
    check("t6_unmapped_held", a_held, 4'b0101);
    send(8'hF0);
    send(8'hF0);
    check("t6_ff_held", a_held, 4'b0101);
    send(8'h16);
    check("t6_release", a_rel, 4'b0100);
    check("t6_held", a_held, 4'b0001);
    @(negedge clk);
    check("t6_release_width", a_rel, 4'b0000);

    // 7: a strobe inside a prefix restarts the timeout count
    perr_seen = 0;
    send(8'hF0);
    repeat (10) begin
      @(negedge clk);
      if (a_perr) perr_seen++;
    end
    send(8'hF0);
    repeat (10) begin
      @(negedge clk);
      if (a_perr) perr_seen++;
    end
    check("t7_no_timeout", perr_seen, 0);
    send(8'h16);
    check("t7_break_unheld_rel", a_rel, 4'b0000);
    check("t7_held", a_held, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
